arb_mux_reg: RTL and testbench

Parametrised N-input, registered multiplexer with valid/ready handshakes on every input and on the output. Generalises the datapath 4:1 select mux: NUM_IN channels, WIDTH-bit data, and two modes.
- Explicit-select mode: the sel port picks the source.
- Round-robin mode: the block arbitrates among valid requesters.

One output register stage decouples timing. It sits between multiple producers (e.g. ALU result, load data, PC+4, immediate) and a single pipelined consumer.

---
 rtl/arb_mux_pkg.sv | 14 +
 rtl/arb_mux_reg_rr_arbiter.sv | 40 ++++
 rtl/arb_mux_reg.sv | 121 ++++++++++++
 tb/tb_arb_mux_reg.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared definitions for arb_mux_reg: mode encodings and the sel clamp helper.
package arb_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  // Out-of-range select values fold onto the highest channel.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned num_in);
    return (sel >= num_in) ? (num_in - 1) : sel;
  endfunction

endpackage

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from a rotating pointer.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  input  logic [SEL_W-1:0]  gnt_idx,
  output logic [NUM_IN-1:0] gnt,
  output logic [SEL_W-1:0]  ptr
);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = (32'(ptr) + k) % NUM_IN;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/arb_mux_reg.sv
// N-input registered mux with valid/ready handshakes, explicit-select or round-robin.
// Optional packet locking enabled by defining ARB_MUX_PKT_LOCK_EN (adds in_last/out_last).
module arb_mux_reg
  import arb_mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 64,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
`ifdef ARB_MUX_PKT_LOCK_EN
  ,
  input  logic [NUM_IN-1:0]       in_last,
  output logic                    out_last
`endif
);

  logic              load_en;
  logic              xfer;
  logic              advance;
  logic [SEL_W-1:0]  cand;
  logic [NUM_IN-1:0] rr_gnt;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  gidx;
  logic [WIDTH-1:0]  gdata;

`ifdef ARB_MUX_PKT_LOCK_EN
  logic              locked;
  logic [SEL_W-1:0]  lock_idx;
`endif

  assign load_en = !out_valid || out_ready;
  assign cand    = SEL_W'(clamp_sel(32'(sel), NUM_IN));

  always_comb begin
    grant = '0;
`ifdef ARB_MUX_PKT_LOCK_EN
    if (locked) begin
      grant[lock_idx] = in_valid[lock_idx];
    end else
`endif
    if (mode == MODE_RR) begin
      grant = rr_gnt;
    end else begin
      grant[cand] = in_valid[cand];
    end
  end

  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        gidx  = SEL_W'(i);
        gdata = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gated by reset so no handshake is advertised while the block is being cleared.
  assign in_ready = (load_en && !reset) ? grant : '0;
  assign xfer     = |in_ready;

`ifdef ARB_MUX_PKT_LOCK_EN
  assign advance = xfer && (mode == MODE_RR) && in_last[gidx];
`else
  assign advance = xfer && (mode == MODE_RR);
`endif

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .clock   (clock),
    .reset   (reset),
    .req     (in_valid),
    .advance (advance),
    .gnt_idx (gidx),
    .gnt     (rr_gnt),
    .ptr     ()
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= gdata;
        out_src  <= gidx;
      end
    end
  end

`ifdef ARB_MUX_PKT_LOCK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      out_last <= 1'b0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (xfer) begin
      out_last <= in_last[gidx];
      locked   <= !in_last[gidx];
      lock_idx <= gidx;
    end
  end
`endif

endmodule

// File: tb/tb_arb_mux_reg.sv
// Self-checking bench for arb_mux_reg against a behavioural transfer-level model.
module tb_arb_mux_reg;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int SW = 2;

  logic           clock = 1'b0;
  logic           reset, mode, out_ready;
  logic [SW-1:0]  sel;
  logic [N-1:0]   in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
`ifdef ARB_MUX_PKT_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif

  int errors = 0;
  int checks = 0;

  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_src, m_ptr;
`ifdef ARB_MUX_PKT_LOCK_EN
  bit           m_locked;
  int           m_lock;
  logic         m_last;
`endif

  always #5 clock = ~clock;

  arb_mux_reg #(.NUM_IN(N), .WIDTH(W), .SEL_W(SW)) dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef ARB_MUX_PKT_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  // Which channel would the spec accept this cycle (as a ready vector).
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int c;
    r = '0;
    if (reset) return r;
    if (m_valid && !out_ready) return r;
`ifdef ARB_MUX_PKT_LOCK_EN
    if (m_locked) begin
      if (in_valid[m_lock]) r[m_lock] = 1'b1;
      return r;
    end
`endif
    if (mode == 1'b0) begin
      c = (int'(sel) >= N) ? N - 1 : int'(sel);
      if (in_valid[c]) r[c] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (in_valid[c]) begin
          r[c] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic tick();
    logic [N-1:0] r;
    int g;
    r = model_ready();
    @(posedge clock);
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
`ifdef ARB_MUX_PKT_LOCK_EN
      m_locked = 0; m_lock = 0; m_last = 1'b0;
`endif
    end else if (!m_valid || out_ready) begin
      if (r != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (r[i]) g = i;
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_src   = g;
`ifdef ARB_MUX_PKT_LOCK_EN
        m_last   = in_last[g];
        m_locked = !in_last[g];
        m_lock   = g;
        if (mode == 1'b1 && in_last[g]) m_ptr = (g + 1) % N;
`else
        if (mode == 1'b1) m_ptr = (g + 1) % N;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '1; out_ready = 1'b1;
    rand_data();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
        errors++; $display("FAIL reset_outputs: got v=%b d=%h s=%0d want 0/0/0", out_valid, out_data, out_src);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_select();
    mode = 1'b0; sel = 2'd2; in_valid = '1; out_ready = 1'b1;
    rand_data();
    in_data[2*W +: W] = 64'hA5;
    #1;
    checks++;
    if (in_ready !== 4'b0100 || in_ready !== model_ready()) begin
      errors++; $display("FAIL sel2_ready: got %b want 0100", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hA5 || out_src !== 2'd2) begin
      errors++; $display("FAIL sel2_out: got v=%b d=%h s=%0d want 1/a5/2", out_valid, out_data, out_src);
    end
    sel = 2'(7);
    rand_data();
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++; $display("FAIL sel7_ready: got %b want 1000", in_ready);
    end
    tick();
    checks++;
    if (out_src !== 2'd3 || out_data !== m_data) begin
      errors++; $display("FAIL sel7_out: got s=%0d d=%h want 3/%h", out_src, out_data, m_data);
    end
    in_valid = 4'b1011; sel = 2'd2;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL sel_invalid_ready: got %b want 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== m_data) begin
      errors++; $display("FAIL sel_bubble: got v=%b d=%h want 0/%h", out_valid, out_data, m_data);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    reset = 1'b1; tick(); reset = 1'b0;
    mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rand_data();
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_src) != exp_seq[c] || out_data !== m_data) begin
        errors++; $display("FAIL rr_seq[%0d]: got v=%b s=%0d d=%h want 1/%0d/%h", c, out_valid, out_src, out_data, exp_seq[c], m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held_d;
    logic [SW-1:0] held_s;
    held_d = out_data; held_s = out_src;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mode = 1'($urandom); sel = 2'($urandom); in_valid = 4'($urandom) | 4'b0001;
      rand_data();
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++; $display("FAIL stall_ready[%0d]: got %b want 0000", c, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_d || out_src !== held_s) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b d=%h s=%0d want 1/%h/%0d", c, out_valid, out_data, out_src, held_d, held_s);
      end
    end
    out_ready = 1'b1; mode = 1'b1; in_valid = '1;
    rand_data();
    #1;
    checks++;
    if (in_ready !== model_ready() || in_ready == '0) begin
      errors++; $display("FAIL release_ready: got %b want %b", in_ready, model_ready());
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== m_data || int'(out_src) != m_src) begin
      errors++; $display("FAIL release_load: got v=%b d=%h s=%0d want 1/%h/%0d", out_valid, out_data, out_src, m_data, m_src);
    end
  endtask

  task automatic test_sparse_rr();
    reset = 1'b1; tick(); reset = 1'b0;
    mode = 1'b1; out_ready = 1'b1; in_valid = '1;
    rand_data();
    tick();
    in_valid = 4'b0001;
    rand_data();
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL sparse_wrap_ready: got %b want 0001", in_ready);
    end
    tick();
    checks++;
    if (out_src !== 2'd0 || out_data !== m_data) begin
      errors++; $display("FAIL sparse_wrap_out: got s=%0d want 0", out_src);
    end
    in_valid = '1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++; $display("FAIL sparse_ptr: got %b want 0010", in_ready);
    end
    tick();
  endtask

`ifdef ARB_MUX_PKT_LOCK_EN
  task automatic test_pkt_lock();
    int   exp_s [4] = '{1, 1, 1, 2};
    logic exp_l [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    reset = 1'b1; tick(); reset = 1'b0;
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0001; in_last = '1;
    rand_data();
    tick();
    in_valid = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      in_last = (c == 2) ? 4'b1111 : 4'b1101;
      rand_data();
      tick();
      checks++;
      if (int'(out_src) != exp_s[c] || out_last !== exp_l[c] || out_data !== m_data) begin
        errors++; $display("FAIL pkt_lock[%0d]: got s=%0d l=%b want %0d/%b", c, out_src, out_last, exp_s[c], exp_l[c]);
      end
    end
    in_last = '1;
  endtask
`endif

  task automatic test_random();
    reset = 1'b1; tick();
    for (int c = 0; c < 300; c++) begin
      reset     = ($urandom_range(0, 40) == 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_MUX_PKT_LOCK_EN
      in_last   = 4'($urandom);
`endif
      rand_data();
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, model_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || int'(out_src) != m_src) begin
        errors++; $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d want %b/%h/%0d", c, out_valid, out_data, out_src, m_valid, m_data, m_src);
      end
`ifdef ARB_MUX_PKT_LOCK_EN
      checks++;
      if (out_last !== m_last) begin
        errors++; $display("FAIL rand_last[%0d]: got %b want %b", c, out_last, m_last);
      end
`endif
    end
    reset = 1'b0;
  endtask

  initial begin
    m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
`ifdef ARB_MUX_PKT_LOCK_EN
    m_locked = 0; m_lock = 0; m_last = 1'b0; in_last = '1;
`endif
    in_data = '0;
    test_reset();
    test_select();
    test_round_robin();
    test_backpressure();
    test_sparse_rr();
`ifdef ARB_MUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
